// File: rtl/regbank_pkg.sv
// Register bank geometry shared by the bank and every client of its write port.
// The one-hot helper maps a register address onto the pending-write mask.
package regbank_pkg;

    localparam int NREGS  = 32;
    localparam int REG_AW = 5;
    localparam int REG_DW = 64;

    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
        return NREGS'(1) << addr;
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_arbiter.sv
// Round-robin picker: combinational, scans from last+1 upward modulo NREQ.
// No backpressure of its own; en low forces an all-zero grant.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o
);

    logic found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_i) + k) % NREQ;
            if (en_i && !found && req_i[idx]) begin
                found       = 1'b1;
                gnt_o[idx]  = 1'b1;
                gnt_idx_o   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Shares the bank write port among NREQ requesters; one-cycle registered latency, one write per cycle.
// Backpressure: req_ready is a round-robin grant, forced low by hold or rst.
module regbank_write_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int AW           = REG_AW,
    parameter int DW           = REG_DW,
    parameter int ZERO_PROTECT = 1,
    parameter int CW           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic [NREGS-1:0]     pend_mask,
    output logic [CW-1:0]        commit_cnt,
    output logic [CW-1:0]        drop_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_idx;
    logic             xfer;
    logic             drop;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;

    logic [IW-1:0]    last_q,   last_d;
    logic             wr_en_q,  wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;
    logic [NREGS-1:0] pend_q,   pend_d;
    logic [CW-1:0]    commit_q, commit_d;
    logic [CW-1:0]    drop_q,   drop_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i     (req_valid),
        .en_i      (!rst && !hold),
        .last_i    (last_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;
    assign sel_addr  = req_addr[gnt_idx*AW +: AW];
    assign sel_data  = req_data[gnt_idx*DW +: DW];
    assign drop      = xfer && (ZERO_PROTECT != 0) && (sel_addr == '0);

    always_comb begin
        last_d    = last_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        commit_d  = commit_q;
        drop_d    = drop_q;
        if (xfer) begin
            last_d    = gnt_idx;
            wr_en_d   = !drop;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end
        if (wr_en_d && (commit_q != '1)) begin
            commit_d = commit_q + 1'b1;
        end
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
        // Mask tracks exactly the registered write that the bank has not yet made readable.
        pend_d = wr_en_d ? reg_onehot(REG_AW'(wr_addr_d)) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= IW'(NREQ - 1);
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pend_q    <= '0;
            commit_q  <= '0;
            drop_q    <= '0;
        end else begin
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pend_q    <= pend_d;
            commit_q  <= commit_d;
            drop_q    <= drop_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign pend_mask  = pend_q;
    assign commit_cnt = commit_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_regbank_write_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 64;
    localparam int CW   = 4;
    localparam int ZP   = 1;
    localparam int MAXC = (1 << CW) - 1;

    logic                clk = 1'b0;
    logic                rst, hold;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic [31:0]         pend_mask;
    logic [CW-1:0]       commit_cnt, drop_cnt;

    always #5 clk = ~clk;

    regbank_write_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_PROTECT(ZP), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_mask(pend_mask), .commit_cnt(commit_cnt), .drop_cnt(drop_cnt)
    );

    // requester-side stimulus state
    bit              v [NREQ];
    logic [AW-1:0]   a [NREQ];
    logic [DW-1:0]   d [NREQ];
    bit              b_rst, b_hold;

    // behavioural model state
    int              m_last;
    bit              m_en;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    int              m_commit, m_drop;
    logic [NREQ-1:0] last_gnt;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] model_grant();
        if (b_rst || b_hold) return '0;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (v[i]) return NREQ'(1) << i;
        end
        return '0;
    endfunction

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    // One clock: drive inputs, check grant, advance the model, check registered outputs after the edge.
    task automatic cyc();
        rst  = b_rst;
        hold = b_hold;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = v[i];
            req_addr[i*AW +: AW]   = a[i];
            req_data[i*DW +: DW]   = d[i];
        end
        #2;
        last_gnt = model_grant();
        chk("req_ready", req_ready, last_gnt);
        if (b_rst) begin
            m_last = NREQ - 1; m_en = 0; m_addr = '0; m_data = '0;
            m_commit = 0; m_drop = 0;
        end else if (last_gnt != '0) begin
            int g;
            g = 0;
            for (int i = 0; i < NREQ; i++) if (last_gnt[i]) g = i;
            m_last = g;
            m_addr = a[g];
            m_data = d[g];
            if (ZP != 0 && a[g] == '0) begin
                m_en = 0;
                m_drop = sat(m_drop + 1);
            end else begin
                m_en = 1;
                m_commit = sat(m_commit + 1);
            end
        end else begin
            m_en = 0;
        end
        @(posedge clk);
        #1;
        chk("wr_en", wr_en, m_en);
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
        chk("pend_mask", pend_mask, m_en ? (32'd1 << m_addr) : 32'd0);
        chk("commit_cnt", commit_cnt, m_commit);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic idle();
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 0; a[i] = '0; d[i] = '0;
        end
    endtask

    task automatic do_reset();
        b_rst = 1;
        cyc();
        b_rst = 0;
    endtask

    initial begin
        b_hold = 0;
        idle();
        do_reset();
        do_reset();
        chk("reset_wr_en", wr_en, 0);
        chk("reset_pend", pend_mask, 0);
        chk("reset_commit", commit_cnt, 0);

        // single write from requester 0
        v[0] = 1; a[0] = 5; d[0] = 64'hDEAD_BEEF;
        cyc();
        chk("first_grant", last_gnt, 3'b001);
        chk("first_wr_en", wr_en, 1);
        chk("first_wr_addr", wr_addr, 5);
        chk("first_wr_data", wr_data, 64'hDEAD_BEEF);
        chk("first_pend", pend_mask, 32'h20);
        chk("first_commit", commit_cnt, 1);
        idle();

        // two requesters contending: strict alternation
        do_reset();
        v[0] = 1; a[0] = 1; v[1] = 1; a[1] = 2;
        for (int k = 0; k < 6; k++) begin
            d[0] = 64'h1000 + k;
            d[1] = 64'h2000 + k;
            cyc();
            chk("alt_grant", last_gnt, (k % 2 == 0) ? 3'b001 : 3'b010);
            chk("alt_data", wr_data, (k % 2 == 0) ? 64'h1000 + k : 64'h2000 + k);
        end
        chk("alt_commit", commit_cnt, 6);
        idle();

        // write to register 0 is accepted but dropped
        v[1] = 1; a[1] = 0; d[1] = 64'h55;
        cyc();
        chk("zero_grant", last_gnt, 3'b010);
        chk("zero_wr_en", wr_en, 0);
        chk("zero_drop", drop_cnt, 1);
        chk("zero_pend", pend_mask, 0);
        chk("zero_commit", commit_cnt, 6);
        idle();

        // hold freezes grants
        v[0] = 1; a[0] = 3; d[0] = 64'h33; v[1] = 1; a[1] = 4; d[1] = 64'h44;
        b_hold = 1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("hold_ready", req_ready, 0);
            chk("hold_wr_en", wr_en, 0);
        end
        b_hold = 0;
        cyc();
        chk("unhold_grant", last_gnt, 3'b001);

        // reset right after an acceptance discards the registered write
        b_rst = 1;
        cyc();
        b_rst = 0;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_commit", commit_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        cyc();
        chk("rst_prio", last_gnt, 3'b001);
        idle();

        // commit counter saturation
        do_reset();
        v[0] = 1; a[0] = 7;
        for (int k = 0; k < 17; k++) begin
            d[0] = 64'(k);
            cyc();
        end
        chk("sat_commit", commit_cnt, 15);
        chk("sat_drop", drop_cnt, 0);
        idle();

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_gnt[i] || !v[i]) begin
                    v[i] = (last_gnt[i]) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
                    a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(0, 31));
                    d[i] = {$urandom, $urandom};
                end else if ($urandom_range(0, 7) == 0) begin
                    v[i] = 0;
                end
            end
            b_hold = ($urandom_range(0, 9) == 0);
            b_rst  = ($urandom_range(0, 99) == 0);
            cyc();
        end
        b_rst = 0;
        b_hold = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
